bcd_clock_core: RTL
===================

Name: bcd_clock_core

Overview:
Timekeeping and time-set core for the six-digit HH:MM:SS clock. It divides the system clock into a 1 Hz time tick and a 2 Hz blink phase, and keeps packed-BCD hours, minutes and seconds. It runs a RUN/SET mode machine driven by single-cycle button pulses. It sits directly upstream of the seven-segment scan multiplexer and drives its hh/mm/ss/blink_en/blink_sel inputs. Button pulses arrive already debounced and edge-detected.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; must be a multiple of 4 and >= 4.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
mode_p  input  1  one-cycle pulse; advances the mode state.
inc_p  input  1  one-cycle pulse; increments the selected field in SET states.
hh  output  8  hours, packed BCD {tens, units}, range 0x00–0x23.
mm  output  8  minutes, packed BCD, range 0x00–0x59.
ss  output  8  seconds, packed BCD, range 0x00–0x59.
blink_en  output  1  high during the "off" half of the 2 Hz blink while in a SET state.
blink_sel  output  2  field being set: 00=HH, 01=MM, 10=SS, 11=none.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values (all outputs registered):
  - hh=mm=ss=0x00, blink_en=0, blink_sel=2'b11.
  - state=RUN, prescaler count=0.
- Prescaler:
  - Free-running count 0..CLK_FREQ-1, wraps to 0.
  - tick is asserted for the single cycle when count==CLK_FREQ-1.
  - Count is forced to 0 on reset and on the SET_SS->RUN transition, so the first second after set lasts a full CLK_FREQ cycles.
- Blink phase:
  - phase=1 when count is in [CLK_FREQ/4, CLK_FREQ/2) or [3*CLK_FREQ/4, CLK_FREQ); otherwise 0. This gives a 2 Hz, 50 % duty waveform.
  - Registered: blink_en <= phase && (state != RUN), one cycle latency.
- States: RUN, SET_HH, SET_MM, SET_SS.
  - mode_p moves RUN->SET_HH->SET_MM->SET_SS->RUN.
  - blink_sel is registered from the next state: 00 in SET_HH, 01 in SET_MM, 10 in SET_SS, 11 in RUN.
- RUN:
  - On tick, ss is incremented in BCD; the units digit goes 9->0 with a carry to tens.
  - ss 0x59->0x00 carries into mm; mm 0x59->0x00 carries into hh; hh 0x23->0x00.
  - 23:59:59 + tick = 00:00:00, all three fields updated in the same cycle.
  - inc_p is ignored in RUN.
- SET states:
  - tick is ignored; the time is frozen.
  - inc_p increments only the selected field, with no carry to other fields. Wraps: hh 0x23->0x00, mm/ss 0x59->0x00.
- Latency: fields update on the clock edge where tick or inc_p is sampled high; new values are visible the next cycle.
- Simultaneous mode_p and inc_p: mode_p wins. The state advances and the field is unchanged.
- tick coinciding with mode_p in RUN: the tick increment is applied and the state enters SET_HH.
- rst asserted mid-SET: next cycle is RUN at 00:00:00 with blink_en=0.
- Fields never hold a non-BCD or out-of-range value.

Decomposition:
- Package clock_pkg holds:
  - the state enum (RUN, SET_HH, SET_MM, SET_SS);
  - BLINK_SEL_HH/MM/SS/NONE 2-bit constants;
  - HH_MAX=8'h23 and MS_MAX=8'h59;
  - a bcd2_t packed typedef {logic [3:0] tens, units}.
- One sub-module, bcd_wrap_inc:
  - parameter MAX (bcd2_t);
  - inputs: value, en;
  - outputs: next value and carry_out.
  - It is instantiated three times and shared by the RUN and SET paths.

Test Plan:
- Use CLK_FREQ=8 throughout.
- Reset, then hold idle 3 cycles -> hh/mm/ss=0x00, blink_en=0, blink_sel=11.
- Run 8 cycles after reset -> ss=0x01. Run 480 cycles -> mm=0x01, ss=0x00.
- Rollover:
  - Set the time to 23:59:59: mode_p, inc_p x23; mode_p, inc_p x59; mode_p, inc_p x59; mode_p.
  - Run 8 cycles -> 00:00:00 in a single cycle.
- Hour set and blink:
  - mode_p -> blink_sel=00; blink_en toggles high 2 cycles / low 2 cycles.
  - inc_p x25 -> hh=0x01 (wrapped at 23); mm and ss unchanged.
  - Further ticks do not change ss.
- Simultaneous pulses: in SET_MM with mm=0x07, assert mode_p and inc_p in the same cycle -> state SET_SS, blink_sel=10, mm stays 0x07.
- Reset mid-SET: in SET_SS with ss=0x30, pulse rst -> next cycle 00:00:00, blink_sel=11, blink_en=0. First ss increment follows 8 cycles after rst is released.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS timekeeping core.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } state_t;

    localparam logic [1:0] BLINK_SEL_HH   = 2'b00;
    localparam logic [1:0] BLINK_SEL_MM   = 2'b01;
    localparam logic [1:0] BLINK_SEL_SS   = 2'b10;
    localparam logic [1:0] BLINK_SEL_NONE = 2'b11;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    localparam bcd2_t HH_MAX = 8'h23;
    localparam bcd2_t MS_MAX = 8'h59;

endpackage

// File: rtl/bcd_wrap_inc.sv
// Two-digit packed-BCD incrementer that wraps MAX -> 00 and flags the wrap.
module bcd_wrap_inc
    import clock_pkg::*;
#(
    parameter bcd2_t MAX = MS_MAX
) (
    input  logic [7:0] value,
    input  logic       en,
    output logic [7:0] nxt_value,
    output logic       carry_out
);

    bcd2_t v;
    assign v = bcd2_t'(value);

    always_comb begin
        nxt_value = value;
        carry_out = 1'b0;
        if (en) begin
            if (v == MAX) begin
                nxt_value = 8'h00;
                carry_out = 1'b1;
            end else if (v.units == 4'd9) begin
                nxt_value = {v.tens + 4'd1, 4'd0};
            end else begin
                nxt_value = {v.tens, v.units + 4'd1};
            end
        end
    end

endmodule

// File: rtl/bcd_clock_core.sv
// Timekeeping core: 1 Hz prescaler, 2 Hz blink phase, BCD time fields and
// the RUN/SET mode machine feeding the seven-segment scan multiplexer.
module bcd_clock_core
    import clock_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_p,
    input  logic       inc_p,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       blink_en,
    output logic [1:0] blink_sel
);

    localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_FREQ - 1);
    localparam logic [CW-1:0] CNT_Q1   = CW'(CLK_FREQ / 4);
    localparam logic [CW-1:0] CNT_Q2   = CW'(CLK_FREQ / 2);
    localparam logic [CW-1:0] CNT_Q3   = CW'(3 * (CLK_FREQ / 4));

    state_t          state, state_nxt;
    logic [1:0]      sel_nxt;
    logic [CW-1:0]   count;
    logic            tick, phase, set_exit;
    logic            run_tick, set_inc;
    logic            ss_en, mm_en, hh_en;
    logic            ss_cy, mm_cy, hh_cy_unused;
    logic [7:0]      ss_inc, mm_inc, hh_inc;

    assign tick     = (count == CNT_LAST);
    assign phase    = ((count >= CNT_Q1) && (count < CNT_Q2)) || (count >= CNT_Q3);
    // Leaving SET_SS restarts the second so it lasts a full CLK_FREQ cycles.
    assign set_exit = (state == SET_SS) && mode_p;

    // mode_p takes priority over inc_p; ticks only advance time in RUN.
    assign run_tick = (state == RUN) && tick;
    assign set_inc  = inc_p && !mode_p;
    assign ss_en    = run_tick || (set_inc && (state == SET_SS));
    assign mm_en    = (run_tick && ss_cy) || (set_inc && (state == SET_MM));
    assign hh_en    = (run_tick && ss_cy && mm_cy) || (set_inc && (state == SET_HH));

    bcd_wrap_inc #(.MAX(MS_MAX)) u_ss_inc (
        .value     (ss),
        .en        (ss_en),
        .nxt_value (ss_inc),
        .carry_out (ss_cy)
    );

    bcd_wrap_inc #(.MAX(MS_MAX)) u_mm_inc (
        .value     (mm),
        .en        (mm_en),
        .nxt_value (mm_inc),
        .carry_out (mm_cy)
    );

    bcd_wrap_inc #(.MAX(HH_MAX)) u_hh_inc (
        .value     (hh),
        .en        (hh_en),
        .nxt_value (hh_inc),
        .carry_out (hh_cy_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            blink_sel <= BLINK_SEL_NONE;
            blink_en  <= 1'b0;
            count     <= '0;
            hh        <= 8'h00;
            mm        <= 8'h00;
            ss        <= 8'h00;
        end else begin
            state     <= state_nxt;
            blink_sel <= sel_nxt;
            blink_en  <= phase && (state != RUN);
            count     <= (tick || set_exit) ? '0 : count + CW'(1);
            hh        <= hh_inc;
            mm        <= mm_inc;
            ss        <= ss_inc;
        end
    end

    always_comb begin
        state_nxt = state;
        if (mode_p) begin
            case (state)
                RUN:     state_nxt = SET_HH;
                SET_HH:  state_nxt = SET_MM;
                SET_MM:  state_nxt = SET_SS;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        sel_nxt = BLINK_SEL_NONE;
        case (state_nxt)
            SET_HH:  sel_nxt = BLINK_SEL_HH;
            SET_MM:  sel_nxt = BLINK_SEL_MM;
            SET_SS:  sel_nxt = BLINK_SEL_SS;
            default: sel_nxt = BLINK_SEL_NONE;
        endcase
    end

endmodule
